// File: rtl/io_bus_master.sv
// io_bus_master
// Serial-style bus master: accepts a 32-bit command word {write, addr, data},
// clocks it out as four MOSI bytes (byte0 first) on a divided bus clock, and
// assembles four MISO bytes into a 32-bit response.
//
// Optional feature (macro IOBUS_RESET_PULSE_EN): after reset release the
// master drives select=0 / clock=0 for 2*CLK_DIV cycles (state BUSRST).
// That combination resets the controller peripherals. Without the macro the
// master is ready in the first cycle after reset.
//
// Ports:
//   iClk, iRst          system clock, synchronous active-high reset
//   iReqValid/oReqReady request handshake
//   iReqWrite/Addr/Data request contents, latched on accept
//   oRspValid/oRspData  one-cycle completion pulse, assembled MISO word
//   oBusClock           bus clock, idle high
//   oBusSelect          bus select, SEL_ID during a transaction
//   oBusMOSI/iBusMISO   byte lanes to/from the controller
//   iBusInterrupt/oIrq  async interrupt in, two-flop synchronized out
module io_bus_master #(
  parameter int          CLK_DIV = 2,
  parameter logic [1:0]  SEL_ID  = 2'b01
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iReqValid,
  output logic        oReqReady,
  input  logic        iReqWrite,
  input  logic [14:0] iReqAddr,
  input  logic [15:0] iReqData,
  output logic        oRspValid,
  output logic [31:0] oRspData,
  output logic        oBusClock,
  output logic [1:0]  oBusSelect,
  output logic [7:0]  oBusMOSI,
  input  logic [7:0]  iBusMISO,
  input  logic        iBusInterrupt,
  output logic        oIrq
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    HIGH,
    LOW,
    DONE
`ifdef IOBUS_RESET_PULSE_EN
    , BUSRST
`endif
  } state_t;

  localparam logic [8:0] DIV_LAST = 9'(CLK_DIV - 1);
`ifdef IOBUS_RESET_PULSE_EN
  localparam logic [8:0] BUSRST_LAST = 9'(2 * CLK_DIV - 1);
  localparam state_t     RESET_STATE = BUSRST;
`else
  localparam state_t     RESET_STATE = IDLE;
`endif

  state_t      state_q, state_d;
  logic [8:0]  cnt_q, cnt_d;
  logic [2:0]  edge_q, edge_d;
  logic [31:0] word_q, word_d;
  logic [31:0] miso_q, miso_d;
  logic [31:0] rspData_q, rspData_d;
  logic [7:0]  mosi_q, mosi_d;
  logic        irqMeta_q, irqSync_q;

  logic        cntLast;
  logic        doneLast;
  logic        accept;
  logic        busClock;
  logic [1:0]  busSel;
  logic        ready;
  logic        rspValid;

  assign cntLast  = (cnt_q == DIV_LAST);
  assign doneLast = (state_q == DONE) && cntLast;
  assign accept   = ready && iReqValid;

  // State and datapath registers; the interrupt synchronizer shares the reset.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q   <= RESET_STATE;
      cnt_q     <= '0;
      edge_q    <= '0;
      word_q    <= '0;
      miso_q    <= '0;
      rspData_q <= '0;
      mosi_q    <= '0;
      irqMeta_q <= 1'b0;
      irqSync_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      edge_q    <= edge_d;
      word_q    <= word_d;
      miso_q    <= miso_d;
      rspData_q <= rspData_d;
      mosi_q    <= mosi_d;
      irqMeta_q <= iBusInterrupt;
      irqSync_q <= irqMeta_q;
    end
  end

  // Moore output decode. The last DONE cycle drops select (clock is high
  // there) and reports completion, so a new request can start immediately.
  // Reset forces the bus to its safe idle levels without waiting for an edge.
  always_comb begin
    busClock = 1'b1;
    busSel   = 2'b00;
    ready    = 1'b0;
    rspValid = 1'b0;
    unique case (state_q)
      IDLE:  ready = 1'b1;
      SETUP: begin
        busClock = 1'b0;
        busSel   = SEL_ID;
      end
      HIGH:  busSel = SEL_ID;
      LOW: begin
        busClock = 1'b0;
        busSel   = SEL_ID;
      end
      DONE: begin
        if (doneLast) begin
          ready    = 1'b1;
          rspValid = 1'b1;
        end else begin
          busSel = SEL_ID;
        end
      end
`ifdef IOBUS_RESET_PULSE_EN
      BUSRST: busClock = 1'b0;
`endif
      default: ;
    endcase
    if (iRst) begin
      busClock = 1'b1;
      busSel   = 2'b00;
      ready    = 1'b0;
      rspValid = 1'b0;
    end
  end

  // Next-state logic. Entering HIGH (or DONE) is a rising bus-clock edge, so
  // MOSI is updated on those transitions; MISO is sampled on the last LOW
  // cycle, just before the next rising edge.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    edge_d    = edge_q;
    word_d    = word_q;
    miso_d    = miso_q;
    rspData_d = rspData_q;
    mosi_d    = mosi_q;
    if (accept) begin
      word_d = {iReqWrite, iReqAddr, iReqData};
    end
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SETUP;
          cnt_d   = '0;
          edge_d  = '0;
        end
      end
      SETUP: begin
        if (cntLast) begin
          state_d = HIGH;
          cnt_d   = '0;
          edge_d  = 3'd1;
          mosi_d  = word_q[7:0];
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end
      HIGH: begin
        if (cntLast) begin
          state_d = LOW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end
      LOW: begin
        if (cntLast) begin
          cnt_d = '0;
          case (edge_q)
            3'd1:    miso_d[7:0]   = iBusMISO;
            3'd2:    miso_d[15:8]  = iBusMISO;
            3'd3:    miso_d[23:16] = iBusMISO;
            3'd4:    miso_d[31:24] = iBusMISO;
            default: ;
          endcase
          if (edge_q == 3'd5) begin
            state_d   = DONE;
            edge_d    = 3'd6;
            rspData_d = miso_q;
          end else begin
            state_d = HIGH;
            edge_d  = edge_q + 3'd1;
            case (edge_q)
              3'd1:    mosi_d = word_q[15:8];
              3'd2:    mosi_d = word_q[23:16];
              3'd3:    mosi_d = word_q[31:24];
              default: mosi_d = 8'h00;
            endcase
          end
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end
      DONE: begin
        if (cntLast) begin
          cnt_d   = '0;
          edge_d  = '0;
          state_d = accept ? SETUP : IDLE;
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end
`ifdef IOBUS_RESET_PULSE_EN
      BUSRST: begin
        if (cnt_q == BUSRST_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  assign oReqReady  = ready;
  assign oRspValid  = rspValid;
  assign oBusClock  = busClock;
  assign oBusSelect = busSel;
  assign oBusMOSI   = iRst ? 8'h00 : mosi_q;
  assign oRspData   = iRst ? 32'h0 : rspData_q;
  assign oIrq       = iRst ? 1'b0 : irqSync_q;

endmodule

// File: tb/tb_io_bus_master.sv
// tb_io_bus_master
// Directed bench for io_bus_master with CLK_DIV=2, SEL_ID=2'b01. A negedge
// monitor counts rising bus-clock edges, logs MOSI at each edge, drives the
// MISO byte for the current edge and flags any select=0/clock=0 cycle.
module tb_io_bus_master;

  logic        iClk = 1'b0;
  logic        iRst;
  logic        iReqValid;
  logic        oReqReady;
  logic        iReqWrite;
  logic [14:0] iReqAddr;
  logic [15:0] iReqData;
  logic        oRspValid;
  logic [31:0] oRspData;
  logic        oBusClock;
  logic [1:0]  oBusSelect;
  logic [7:0]  oBusMOSI;
  logic [7:0]  iBusMISO = 8'h00;
  logic        iBusInterrupt;
  logic        oIrq;

  int          nVec = 0;
  int          nFail = 0;
  int          riseTotal = 0;
  int          riseBase = 0;
  int          violations = 0;
  logic        prevClk = 1'b1;
  logic        inBusRst = 1'b0;
  logic [7:0]  misoTab [4];
  logic [7:0]  mosiLog [8];
  int          cycles;
  int          k;

  io_bus_master #(.CLK_DIV(2), .SEL_ID(2'b01)) dut (
    .iClk(iClk), .iRst(iRst),
    .iReqValid(iReqValid), .oReqReady(oReqReady),
    .iReqWrite(iReqWrite), .iReqAddr(iReqAddr), .iReqData(iReqData),
    .oRspValid(oRspValid), .oRspData(oRspData),
    .oBusClock(oBusClock), .oBusSelect(oBusSelect),
    .oBusMOSI(oBusMOSI), .iBusMISO(iBusMISO),
    .iBusInterrupt(iBusInterrupt), .oIrq(oIrq)
  );

  always #5 iClk = ~iClk;

  // Bus-side model: edge counting, MOSI logging, MISO driving, safety check.
  always @(negedge iClk) begin
    int idx;
    if (oBusClock && !prevClk) begin
      riseTotal = riseTotal + 1;
      idx = riseTotal - riseBase;
      if (idx >= 0 && idx < 8) mosiLog[idx] = oBusMOSI;
      iBusMISO = (idx >= 1 && idx <= 4) ? misoTab[idx-1] : 8'h00;
    end
    prevClk = oBusClock;
    if (!inBusRst && !iRst && oBusSelect == 2'b00 && !oBusClock)
      violations = violations + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nVec = nVec + 1;
    assert (obs === exp) else begin
      nFail = nFail + 1;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Releases reset and checks when the master first becomes ready.
  task automatic releaseReset();
    iRst = 1'b0;
`ifdef IOBUS_RESET_PULSE_EN
    inBusRst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge iClk);
      checkOutput("busRstLevels", {29'd0, oBusSelect, oBusClock}, 32'h0);
      checkOutput("busRstReady", {31'd0, oReqReady}, 32'h0);
    end
    inBusRst = 1'b0;
`endif
    @(negedge iClk);
    checkOutput("readyAfterReset", {31'd0, oReqReady}, 32'h1);
  endtask

  // Issues one request from a negedge and counts cycles from accept to oRspValid.
  task automatic applyStimulus(input logic wr, input logic [14:0] addr, input logic [15:0] data,
                               input logic hold, output int n);
    riseBase  = riseTotal;
    iReqValid = 1'b1;
    iReqWrite = wr;
    iReqAddr  = addr;
    iReqData  = data;
    @(posedge iClk);
    @(negedge iClk);
    checkOutput("readyDrop", {31'd0, oReqReady}, 32'h0);
    if (!hold) iReqValid = 1'b0;
    n = 1;
    while (!oRspValid && n < 200) begin
      @(negedge iClk);
      n = n + 1;
    end
  endtask

  initial begin
    iRst = 1'b1;
    iReqValid = 1'b0;
    iReqWrite = 1'b0;
    iReqAddr = '0;
    iReqData = '0;
    iBusInterrupt = 1'b0;
    for (int i = 0; i < 4; i++) misoTab[i] = 8'h00;
    for (int i = 0; i < 8; i++) mosiLog[i] = 8'h00;
    repeat (3) @(negedge iClk);

    // Reset values
    checkOutput("rstReady", {31'd0, oReqReady}, 32'h0);
    checkOutput("rstClock", {31'd0, oBusClock}, 32'h1);
    checkOutput("rstSelect", {30'd0, oBusSelect}, 32'h0);
    checkOutput("rstMosi", {24'd0, oBusMOSI}, 32'h0);
    checkOutput("rstRspValid", {31'd0, oRspValid}, 32'h0);
    checkOutput("rstRspData", oRspData, 32'h0);
    checkOutput("rstIrq", {31'd0, oIrq}, 32'h0);
    releaseReset();

    // Write 0x0034 / 0x0123, MISO returns 0x44332211
    misoTab[0] = 8'h11; misoTab[1] = 8'h22; misoTab[2] = 8'h33; misoTab[3] = 8'h44;
    applyStimulus(1'b1, 15'h0034, 16'h0123, 1'b0, cycles);
    checkOutput("wrLatency", 32'(cycles), 32'd24);
    checkOutput("wrMosi1", {24'd0, mosiLog[1]}, 32'h23);
    checkOutput("wrMosi2", {24'd0, mosiLog[2]}, 32'h01);
    checkOutput("wrMosi3", {24'd0, mosiLog[3]}, 32'h34);
    checkOutput("wrMosi4", {24'd0, mosiLog[4]}, 32'h80);
    checkOutput("wrMosi5", {24'd0, mosiLog[5]}, 32'h00);
    checkOutput("wrRises", 32'(riseTotal - riseBase), 32'd6);
    checkOutput("wrRspData", oRspData, 32'h44332211);
    checkOutput("wrValidSelect", {30'd0, oBusSelect}, 32'h0);
    checkOutput("wrValidReady", {31'd0, oReqReady}, 32'h1);
    @(negedge iClk);
    checkOutput("wrPulseOnce", {31'd0, oRspValid}, 32'h0);
    checkOutput("wrDataHeld", oRspData, 32'h44332211);

    // Read 0x0300, MISO EF BE AD DE
    misoTab[0] = 8'hEF; misoTab[1] = 8'hBE; misoTab[2] = 8'hAD; misoTab[3] = 8'hDE;
    applyStimulus(1'b0, 15'h0300, 16'h0000, 1'b0, cycles);
    checkOutput("rdLatency", 32'(cycles), 32'd24);
    checkOutput("rdMosi1", {24'd0, mosiLog[1]}, 32'h00);
    checkOutput("rdMosi3", {24'd0, mosiLog[3]}, 32'h00);
    checkOutput("rdMosi4", {24'd0, mosiLog[4]}, 32'h03);
    checkOutput("rdRspData", oRspData, 32'hDEADBEEF);

    // Back-to-back with iReqValid held high
    misoTab[0] = 8'hA1; misoTab[1] = 8'hB2; misoTab[2] = 8'hC3; misoTab[3] = 8'hD4;
    @(negedge iClk);
    applyStimulus(1'b1, 15'h0001, 16'h5555, 1'b1, cycles);
    checkOutput("b2bLatency1", 32'(cycles), 32'd24);
    checkOutput("b2bReadyOnValid", {31'd0, oReqReady}, 32'h1);
    checkOutput("b2bRises1", 32'(riseTotal - riseBase), 32'd6);
    riseBase = riseTotal;
    @(posedge iClk);
    @(negedge iClk);
    checkOutput("b2bAccepted", {31'd0, oReqReady}, 32'h0);
    iReqValid = 1'b0;
    cycles = 1;
    while (!oRspValid && cycles < 200) begin
      @(negedge iClk);
      cycles = cycles + 1;
    end
    checkOutput("b2bLatency2", 32'(cycles), 32'd24);
    checkOutput("b2bRises2", 32'(riseTotal - riseBase), 32'd6);
    checkOutput("b2bMosi3", {24'd0, mosiLog[3]}, 32'h01);
    checkOutput("b2bRspData", oRspData, 32'hD4C3B2A1);

    // Reset after rising edge 3, then a normal read
    @(negedge iClk);
    riseBase = riseTotal;
    iReqValid = 1'b1;
    iReqWrite = 1'b1;
    iReqAddr = 15'h7FFF;
    iReqData = 16'hFFFF;
    @(posedge iClk);
    @(negedge iClk);
    iReqValid = 1'b0;
    k = 0;
    while ((riseTotal - riseBase) < 3 && k < 100) begin
      @(negedge iClk);
      k = k + 1;
    end
    checkOutput("abortAtEdge3", 32'(riseTotal - riseBase), 32'd3);
    iRst = 1'b1;
    @(negedge iClk);
    checkOutput("abortClock", {31'd0, oBusClock}, 32'h1);
    checkOutput("abortSelect", {30'd0, oBusSelect}, 32'h0);
    checkOutput("abortRspValid", {31'd0, oRspValid}, 32'h0);
    checkOutput("abortMosi", {24'd0, oBusMOSI}, 32'h0);
    @(negedge iClk);
    releaseReset();
    misoTab[0] = 8'h12; misoTab[1] = 8'h34; misoTab[2] = 8'h56; misoTab[3] = 8'h78;
    applyStimulus(1'b0, 15'h0010, 16'h0000, 1'b0, cycles);
    checkOutput("postAbortLatency", 32'(cycles), 32'd24);
    checkOutput("postAbortRspData", oRspData, 32'h78563412);

    // Interrupt synchronizer
    @(negedge iClk);
    iBusInterrupt = 1'b1;
    @(negedge iClk);
    checkOutput("irqAfter1", {31'd0, oIrq}, 32'h0);
    @(negedge iClk);
    checkOutput("irqAfter2", {31'd0, oIrq}, 32'h1);

    checkOutput("selClkLowNever", 32'(violations), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

endmodule

// File: doc/io_bus_master.md
IO_BUS_MASTER -- requirements
Module: io_bus_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2: half-period of oBusClock in iClk cycles, legal range 1..255.
REQ-002 SHALL have parameter SEL_ID, default 2'b01: value driven on oBusSelect during a transaction; 2'b00 is illegal.
REQ-003 SHALL have port iClk, input, 1: system clock; all logic on posedge.
REQ-004 SHALL have port iRst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port iReqValid, input, 1: request present.
REQ-006 SHALL have port oReqReady, output, 1: master idle, request accepted when iReqValid && oReqReady.
REQ-007 SHALL have port iReqWrite, input, 1: 1 = write, 0 = read.
REQ-008 SHALL have port iReqAddr, input, 15: peripheral address.
REQ-009 SHALL have port iReqData, input, 16: write data (ignored by peripheral on read).
REQ-010 SHALL have port oRspValid, output, 1: one-cycle pulse, transaction complete.
REQ-011 SHALL have port oRspData, output, 32: assembled MISO word, held until next oRspValid.
REQ-012 SHALL have port oBusClock, output, 1: bus clock, idle level high.
REQ-013 SHALL have port oBusSelect, output, 2: bus select.
REQ-014 SHALL have port oBusMOSI, output, 8: byte to controller.
REQ-015 SHALL have port iBusMISO, input, 8: byte from controller.
REQ-016 SHALL have port iBusInterrupt, input, 1: asynchronous controller interrupt.
REQ-017 SHALL have port oIrq, output, 1: iBusInterrupt synchronized through two iClk flops.

Function
REQ-018 SHALL latch word W = {iReqWrite, iReqAddr, iReqData} on the accept cycle; oReqReady SHALL deassert the following cycle.
REQ-019 SHALL use states IDLE -> SETUP -> HIGH <-> LOW -> DONE -> IDLE, with a divider counter (0..CLK_DIV-1) and a rising-edge counter E (1..6).
REQ-020 SETUP: oBusClock=0, oBusSelect=SEL_ID, oBusMOSI=0, for CLK_DIV cycles.
REQ-021 Each SETUP/LOW exit SHALL raise oBusClock (rising edge E); HIGH lasts CLK_DIV cycles, then LOW lasts CLK_DIV cycles, for E=1..5.
REQ-022 On rising edge E=1..4 oBusMOSI SHALL change to W[8E-1:8E-8] (byte0 first) and hold stable through the following falling edge.
REQ-023 On rising edge E=5, oBusMOSI SHALL return to 0.
REQ-024 In the last iClk cycle of LOW following rising edge E=1..4, iBusMISO SHALL be captured into oRspData[8E-1:8E-8].
REQ-025 After rising edge E=6, oBusClock SHALL stay high for CLK_DIV cycles (state DONE).
REQ-026 At DONE exit, oBusSelect SHALL go to 0, oRspValid SHALL pulse one cycle, and oReqReady SHALL reassert in the same cycle; the next request can be accepted that cycle.
REQ-027 Transaction length SHALL be exactly 12*CLK_DIV cycles from the accept cycle to the oRspValid cycle.
REQ-028 oBusSelect=0 SHALL never coincide with oBusClock=0 outside the optional bus-reset pulse, because that combination resets the controller peripherals.
REQ-029 iReqValid while busy SHALL be ignored; no queuing.
REQ-030 Write transactions SHALL also return the captured MISO word on oRspData.

Reset
REQ-031 While iRst is high: state IDLE; oBusClock=1; oBusSelect=0; oBusMOSI=0; oRspValid=0; oRspData=0; oIrq=0; counters=0; oReqReady=0.
REQ-032 iRst mid-transaction SHALL abort it within one cycle to the REQ-031 values, with no oRspValid.
REQ-033 oReqReady SHALL be 1 in the first cycle after iRst deasserts, unless REQ-034 applies.

Configuration
REQ-034 With IOBUS_RESET_PULSE_EN defined, after iRst deasserts the master SHALL enter state BUSRST: oBusSelect=0 and oBusClock=0 for 2*CLK_DIV cycles, then oBusClock=1 and IDLE; oReqReady=0 during BUSRST. Without the macro, BUSRST SHALL not exist and REQ-033 applies.

Verification
REQ-035 CLK_DIV=2, write addr 0x0034 data 0x0123 -> oBusMOSI bytes 0x23, 0x01, 0x34, 0x80 on edges 1-4; oRspValid 24 cycles after accept.
REQ-036 CLK_DIV=2, read addr 0x0300; bench drives MISO 0xEF, 0xBE, 0xAD, 0xDE in LOW phases 1-4 -> oRspData=0xDEADBEEF; MOSI bytes 0x00, 0x00, 0x00, 0x03.
REQ-037 Back-to-back requests with iReqValid held high -> second accepted on the first oRspValid cycle; exactly 6 rising edges per transaction; no cycle with select=0 and clock=0.
REQ-038 iRst asserted after rising edge E=3 -> next cycle oBusClock=1, oBusSelect=0, no oRspValid; a new request then completes normally.
REQ-039 iBusInterrupt 0->1 -> oIrq=1 exactly two iClk cycles later.
REQ-040 With IOBUS_RESET_PULSE_EN defined and CLK_DIV=2, release iRst -> 4 cycles of select=0/clock=0, then oReqReady=1.
